// File: rtl/array_access_ctrl.sv
// Controller for the single-port array macro: clears every word after reset,
// then arbitrates core read/write requests onto RW0 and queues read results.
module array_access_ctrl #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 100,
  parameter int MASK_W     = 4,
  parameter int RESP_DEPTH = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [MASK_W-1:0] req_mask,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [MASK_W-1:0] RW0_wmask,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt;
  logic [CNT_W-1:0]  fifo_count;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              inflight;
  logic [DATA_W-1:0] fifo_mem [RESP_DEPTH];
  logic [CNT_W:0]    credits_used;
  logic              fire, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A read in flight already owns a FIFO slot, so the credit check makes
  // the unconditional capture safe.
  assign credits_used = {1'b0, fifo_count} + (CNT_W+1)'(inflight);
  assign req_ready    = (state_q == S_RUN) && (credits_used < (CNT_W+1)'(RESP_DEPTH));
  assign fire         = req_valid && req_ready;
  assign push         = inflight;
  assign resp_valid   = (fifo_count != '0);
  assign pop          = resp_valid && resp_ready;
  assign resp_data    = fifo_mem[rd_ptr];
  assign init_done    = (state_q == S_RUN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_INIT;
      init_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_INIT && init_cnt == '1) state_d = S_RUN;
  end

  // Reset gates the port so the macro sees nothing while reset is held.
  always_comb begin
    RW0_en    = 1'b0;
    RW0_wmode = 1'b0;
    RW0_wmask = '0;
    RW0_addr  = '0;
    RW0_wdata = '0;
    if (!reset) begin
      case (state_q)
        S_INIT: begin
          RW0_en    = 1'b1;
          RW0_wmode = 1'b1;
          RW0_wmask = '1;
          RW0_addr  = init_cnt;
        end
        S_RUN: if (fire) begin
          RW0_en    = 1'b1;
          RW0_wmode = req_write;
          RW0_wmask = req_mask;
          RW0_addr  = req_addr;
          RW0_wdata = req_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      inflight <= fire && !req_write;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= RW0_rdata;
  end

endmodule

// File: doc/array_access_ctrl.md
# array_access_ctrl

Initiator-side controller for the 128×100-bit single-port array macro (RW0 port: addr/en/wmode/wmask/wdata in, 1-cycle registered-address rdata out). It clears the whole array after reset, then arbitrates valid/ready read and write requests from the core onto the RW0 port. It captures each read result the cycle after issue into a small response FIFO so that backpressure never loses data. It sits between the core-side access logic and the array macro instance.

## Interface
Parameters:
- ADDR_W, 7, array address width; depth = 2^ADDR_W = 128
- DATA_W, 100, array word width
- MASK_W, 4, write-mask lanes; lane width = DATA_W/MASK_W = 25
- RESP_DEPTH, 3, response FIFO entries (must be ≥3 for full read throughput)

Ports:
- clock  input  1  single clock for the block and the array
- reset  input  1  asynchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid && req_ready (fire)
- req_write  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  word address
- req_mask  input  MASK_W  write lane enables; ignored for reads
- req_data  input  DATA_W  write data
- resp_valid  output  1  read data available
- resp_ready  input  1  consumer takes resp_data when resp_valid && resp_ready
- resp_data  output  DATA_W  read data, FIFO head
- init_done  output  1  array clear finished; requests are accepted only when high
- RW0_addr  output  ADDR_W  to macro
- RW0_en  output  1  to macro
- RW0_wmode  output  1  to macro
- RW0_wmask  output  MASK_W  to macro
- RW0_wdata  output  DATA_W  to macro
- RW0_rdata  input  DATA_W  from macro; valid the cycle after a read is issued

## Operation
- States: INIT → RUN. Reset forces INIT, init_cnt=0, FIFO empty, inflight=0.
- INIT: every cycle drive RW0_en=1, wmode=1, wmask=all ones, wdata=0, addr=init_cnt; init_cnt increments. After the write to address 127, the block moves to RUN and init_done goes high. req_ready=0 throughout INIT.
- RUN: req_ready = (fifo_count + inflight < RESP_DEPTH). It does not depend on req_valid, req_write, or resp_ready.
- On fire: RW0 signals are driven combinationally from the request in the same cycle (en=1, wmode=req_write, addr, mask, data). With no fire, RW0_en=0 and the other RW0 outputs are don't-care (drive 0).
- Writes are posted: no response. Lanes with req_mask[i]=0 are untouched; mask=0 is a legal no-op write.
- Read fire sets inflight=1 for the next cycle. In that cycle RW0_rdata is pushed into the FIFO unconditionally; the credit check guarantees space.
- FIFO pop on resp_valid && resp_ready. Simultaneous push and pop in the same cycle are legal; the count is unchanged.
- Ordering: responses are returned in request order. A read after a write to the same address returns the written data (the macro is in-order). A write issued in the cycle the previous read's data is captured does not corrupt the capture, because capture happens in that same cycle.
- fifo_count width is clog2(RESP_DEPTH+1). Pointers wrap modulo RESP_DEPTH.

## Timing
- Reset values (asserted and immediately after): req_ready=0, resp_valid=0, init_done=0, RW0_en=0, RW0_wmode=0, RW0_wmask=0, RW0_addr=0, RW0_wdata=0.
- INIT occupies the first 2^ADDR_W=128 clock edges after reset deasserts. init_done is high from cycle 128 (cycle 0 = first edge after deassert). req_ready can first be high in that same cycle.
- Read latency: fire in cycle N, RW0_rdata valid in N+1, captured at the end of N+1, resp_valid high from N+2.
- Throughput: with resp_ready held high, one read per cycle sustained indefinitely. With resp_ready low, at most RESP_DEPTH reads are outstanding, then req_ready drops and writes are also stalled.
- Reset mid-operation (any state): in-flight reads and FIFO contents are discarded, outputs return to reset values, and INIT restarts from address 0.

## Test plan
- Reset deassert → 128 consecutive RW0 writes, addr 0..127, wmask=4'hF, wdata=0; init_done rises at cycle 128. Then reads of addresses 0, 64, and 127 return 0.
- Write addr 5, mask 4'b0101, data with lane k = k+1 (25-bit each), then read addr 5 → resp_data lanes = {0,3,0,1} (lane3..lane0); resp_valid 2 cycles after read fire.
- resp_ready=1, 20 back-to-back reads of addr 0..19 preloaded with value=addr → 20 responses on consecutive cycles, in order, req_ready never drops.
- resp_ready=0, reads offered continuously → exactly 3 fires, then req_ready=0 and RW0_en=0. Raise resp_ready → 3 responses in order, and req_ready reasserts in the first cycle the count drops below 3.
- Write addr 9 = A in cycle N, read addr 9 in N+1, write addr 9 = B in N+2 → single response A.
- Assert reset with 2 responses queued and 1 in flight → resp_valid=0 immediately, no stale response after reset, init sweep restarts at addr 0.
